// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;
  localparam int DATA_WIDTH = 32;

  // One slot of the read-latency pipeline.
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } mem_rsp_t;

  // base <= addr < base + WORD_BYTES*depth. Arguments are zero-extended to
  // 64 bits, so the subtraction cannot wrap for any legal address width.
  // Comparing the word offset against depth is the same as comparing the
  // byte offset against 4*depth.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] depth);
    return (addr >= base) && (((addr - base) >> BYTE_OFF_W) < depth);
  endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Fixed-latency shift register of read responses with synchronous clear.
// The last stage is the registered output; its data holds between responses.
module rd_latency_pipe #(
  parameter int LATENCY    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);
  import mem_pkg::*;

  mem_rsp_t pipe_q [LATENCY];
  mem_rsp_t pipe_d [LATENCY];

  // Advance valid every cycle; a stage only loads data when a valid entry
  // moves into it, so the output word is held while idle.
  always_comb begin
    pipe_d[0].valid = in_valid;
    pipe_d[0].data  = in_valid ? in_data : pipe_q[0].data;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i].valid = pipe_q[i-1].valid;
      pipe_d[i].data  = pipe_q[i-1].valid ? pipe_q[i-1].data : pipe_q[i].data;
    end
  end

  // Pipeline register; reset drops every in-flight response.
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '{default: '0};
    else     pipe_q <= pipe_d;
  end

  assign out_valid = pipe_q[LATENCY-1].valid;
  assign out_data  = pipe_q[LATENCY-1].data;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the writeback load/store port:
// fixed-latency loads, immediate store commit, write-first bypass, sticky
// out-of-range error flag.
module data_mem_responder #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd_en,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rdata_valid,
  input  logic                  mem_write_en,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic                  mem_err
);
  import mem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic             rd_ok, wr_ok, init_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx, init_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic             mem_err_d, mem_err_q;

  // Byte address to word index; addr[1:0] drops out in the shift.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return IDX_W'(off >> BYTE_OFF_W);
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return in_range(64'(addr), 64'(BASE_ADDR), 64'(DEPTH));
  endfunction

  // Decode all three ports and pick the load word (write-first on a hit).
  always_comb begin
    rd_ok    = addr_ok(mem_raddr);
    wr_ok    = mem_write_en && addr_ok(mem_waddr);
    init_ok  = init_we && addr_ok(init_addr);
    rd_idx   = word_idx(mem_raddr);
    wr_idx   = word_idx(mem_waddr);
    init_idx = word_idx(init_addr);
    rd_word  = '0;
    if (rd_ok) rd_word = (wr_ok && wr_idx == rd_idx) ? mem_wdata : ram[rd_idx];
  end

  // Array update; the store is assigned last so it wins a same-index clash
  // with a preload. Contents survive reset.
  always_ff @(posedge clk) begin
    if (init_ok) ram[init_idx] <= init_data;
    if (wr_ok)   ram[wr_idx]   <= mem_wdata;
  end

  // Sticky error: any out-of-range load or store; preloads never set it.
  always_comb begin
    mem_err_d = mem_err_q
              | (mem_rd_en && !rd_ok)
              | (mem_write_en && !addr_ok(mem_waddr));
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) mem_err_q <= 1'b0;
    else     mem_err_q <= mem_err_d;
  end

  assign mem_err = mem_err_q;

  rd_latency_pipe #(
    .LATENCY   (READ_LATENCY),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (mem_rd_en),
    .in_data  (rd_word),
    .out_valid(mem_rdata_valid),
    .out_data (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder.
module tb_data_mem_responder;
  localparam int          L     = 2;
  localparam int          DEPTH = 1024;
  localparam longint      BASE  = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en, mem_write_en, init_we;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, init_addr, init_data;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid, mem_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
    .BASE_ADDR(32'(BASE)), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_write_en(mem_write_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .mem_err(mem_err)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DEPTH];
  bit          err_exp;
  int          edge_n;
  bit          mon_en;
  int          checks, errors;

  function automatic bit ok(logic [31:0] a);
    longint v = longint'(a);
    return v >= BASE && v < BASE + 4 * DEPTH;
  endfunction

  function automatic int idx(logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  // One clock edge: the reference model consumes the inputs the DUT samples.
  task automatic step();
    exp_t e;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      sbq.delete();
      err_exp = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (!ok(mem_raddr)) e.data = 32'h0;
        else if (mem_write_en && ok(mem_waddr) && idx(mem_waddr) == idx(mem_raddr))
          e.data = mem_wdata;
        else e.data = model[idx(mem_raddr)];
        e.due = edge_n + L - 1;
        sbq.push_back(e);
        if (!ok(mem_raddr)) err_exp = 1'b1;
      end
      if (mem_write_en && !ok(mem_waddr)) err_exp = 1'b1;
      if (init_we && ok(init_addr))      model[idx(init_addr)] = init_data;
      if (mem_write_en && ok(mem_waddr)) model[idx(mem_waddr)] = mem_wdata;
    end
    #1;
  endtask

  task automatic idle();
    mem_rd_en = 0; mem_write_en = 0; init_we = 0;
  endtask

  task automatic rd(logic [31:0] a);
    idle(); mem_rd_en = 1; mem_raddr = a; step(); idle();
  endtask

  task automatic ld(logic [31:0] a, logic [31:0] d);
    idle(); init_we = 1; init_addr = a; init_data = d; step(); idle();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < L + 1; i++) step();
  endtask

  // Monitor: every cycle, the DUT must present exactly the response due now.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == edge_n) begin
        chk("rsp_valid", 32'(mem_rdata_valid), 32'd1);
        chk("rsp_data", mem_rdata, sbq[0].data);
        void'(sbq.pop_front());
      end else begin
        chk("idle_valid", 32'(mem_rdata_valid), 32'd0);
      end
      chk("mem_err", 32'(mem_err), 32'(err_exp));
    end
  end

  initial begin
    rst = 1; idle();
    mem_raddr = 0; mem_waddr = 0; mem_wdata = 0; init_addr = 0; init_data = 0;
    step();
    mon_en = 1;
    step();
    chk("rst_rdata", mem_rdata, 32'h0);
    rst = 0;

    for (int i = 0; i < DEPTH; i++) ld(32'(i * 4), $urandom);

    // Preloaded word with fixed latency.
    ld(32'h100, 32'hDEADBEEF);
    rd(32'h100);
    drain();

    // Write-first on a same-cycle store and load.
    idle();
    mem_write_en = 1; mem_waddr = 32'h104; mem_wdata = 32'h12345678;
    mem_rd_en = 1; mem_raddr = 32'h104;
    step();
    drain();

    // Back-to-back loads.
    rd(32'h100); rd(32'h104); rd(32'h108);
    drain();

    // Low address bits ignored.
    ld(32'h100, 32'hAABBCCDD);
    rd(32'h102);
    drain();

    // Store beats preload on the same word.
    idle();
    init_we = 1; init_addr = 32'h200; init_data = 32'h11111111;
    mem_write_en = 1; mem_waddr = 32'h200; mem_wdata = 32'h22222222;
    step();
    rd(32'h200);
    drain();

    // Out-of-range load and store; word 0 must stay untouched.
    rd(32'h1000);
    idle(); mem_write_en = 1; mem_waddr = 32'h1000; mem_wdata = 32'hFFFFFFFF; step();
    rd(32'h0);
    drain();

    // Reset with a load in flight: no response, array kept, error cleared.
    rd(32'h100);
    rst = 1; step(); rst = 0;
    drain();
    rd(32'h100);
    drain();

    // Randomized traffic focused on a small window to create collisions.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst          = ($urandom_range(0, 199) == 0);
      mem_rd_en    = ($urandom_range(0, 9) < 7);
      mem_write_en = !rst && ($urandom_range(0, 9) < 3);
      init_we      = !rst && ($urandom_range(0, 9) == 0);
      mem_raddr    = ($urandom_range(0, 19) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                                  : $urandom_range(0, 255);
      mem_waddr    = ($urandom_range(0, 29) == 0) ? 32'hFFFF_0000 | $urandom_range(0, 255)
                                                  : $urandom_range(0, 255);
      mem_wdata    = $urandom;
      init_addr    = ($urandom_range(0, 9) == 0) ? 32'h2000 : $urandom_range(0, 255);
      init_data    = $urandom;
      step();
    end
    rst = 0;
    drain();
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
